light_map_server: RTL and testbench

- Double-buffered zone brightness store on the video side of the MiniLED path.
- Write side: per-zone 16-bit brightness values from the LVDS video statistics logic, written into a back bank.
- Read side: answers the driver's `light_index` requests with `mapped_light`.
- On the driver's `light_refresh` pulse, the read side swaps to the most recently completed frame.

---
 rtl/light_map_server_if.sv | 28 ++
 rtl/light_map_server.sv | 109 ++++++++++
 tb/tb_light_map_server.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/light_map_server_if.sv
// Zone write / driver read bundle for light_map_server.
// master drives the stimulus side, slave is the map server.
interface light_map_server_if #(
  parameter int IDX_W  = 9,
  parameter int DATA_W = 16
);
  logic              zone_valid;
  logic [IDX_W-1:0]  zone_index;
  logic [DATA_W-1:0] zone_value;
  logic              frame_done;
  logic              light_refresh;
  logic [IDX_W-1:0]  light_index;
  logic [DATA_W-1:0] mapped_light;
  logic              frame_pending;
  logic [7:0]        drop_cnt;

  modport master (
    output zone_valid, zone_index, zone_value, frame_done,
    output light_refresh, light_index,
    input  mapped_light, frame_pending, drop_cnt
  );

  modport slave (
    input  zone_valid, zone_index, zone_value, frame_done,
    input  light_refresh, light_index,
    output mapped_light, frame_pending, drop_cnt
  );
endinterface

// File: rtl/light_map_server.sv
// Double-buffered MiniLED zone brightness store with frame swap.
// Optional gamma-2 read stage: define LIGHT_MAP_GAMMA_EN.
module light_map_server #(
  parameter int ZONES  = 288,
  parameter int IDX_W  = 9,
  parameter int DATA_W = 16
) (
  input logic I_clk,
  input logic sys_rst,
  light_map_server_if.slave bus
);
  typedef enum logic {W_FILL, W_WAIT} wstate_t;

  localparam int DEPTH = 2 << IDX_W;
  localparam logic [IDX_W:0] ZLIM = (IDX_W+1)'(ZONES);

  logic [DATA_W-1:0] mem [DEPTH];

  wstate_t           st_q, st_d;
  logic              rd_bank_q, rd_bank_d;
  logic              wr_bank_q, wr_bank_d;
  logic              pend_q, pend_d;
  logic              ok_q, ok_d;
  logic [7:0]        drop_q, drop_d;
  logic [DATA_W-1:0] raw_q, raw_d;

  logic wr_hit;
  logic rd_hit;
  logic swap;

  always_comb begin
    wr_hit = bus.zone_valid && (st_q == W_FILL)
          && ({1'b0, bus.zone_index} < ZLIM);
    rd_hit = ok_q && ({1'b0, bus.light_index} < ZLIM);
    swap   = bus.light_refresh
          && (pend_q || (st_q == W_FILL && bus.frame_done));

    st_d      = st_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;
    pend_d    = pend_q;
    ok_d      = ok_q;
    drop_d    = drop_q;

    if (st_q == W_WAIT && bus.zone_valid && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;

    if (swap) begin
      rd_bank_d = wr_bank_q;
      wr_bank_d = rd_bank_q;
      pend_d    = 1'b0;
      ok_d      = 1'b1;
      st_d      = W_FILL;
    end else if (st_q == W_FILL && bus.frame_done) begin
      pend_d = 1'b1;
      st_d   = W_WAIT;
    end

    // Read sees the bank selected before any swap in this cycle.
    raw_d = rd_hit ? mem[{rd_bank_q, bus.light_index}] : '0;
  end

  always_ff @(posedge I_clk) begin
    if (wr_hit)
      mem[{wr_bank_q, bus.zone_index}] <= bus.zone_value;
  end

  always_ff @(posedge I_clk or posedge sys_rst) begin
    if (sys_rst) begin
      st_q      <= W_FILL;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b1;
      pend_q    <= 1'b0;
      ok_q      <= 1'b0;
      drop_q    <= '0;
      raw_q     <= '0;
    end else begin
      st_q      <= st_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      pend_q    <= pend_d;
      ok_q      <= ok_d;
      drop_q    <= drop_d;
      raw_q     <= raw_d;
    end
  end

`ifdef LIGHT_MAP_GAMMA_EN
  logic [2*DATA_W-1:0] sq;
  logic [DATA_W-1:0]   gam_q, gam_d;

  always_comb begin
    sq    = raw_q * raw_q;
    gam_d = sq[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge I_clk or posedge sys_rst) begin
    if (sys_rst) gam_q <= '0;
    else         gam_q <= gam_d;
  end

  assign bus.mapped_light = gam_q;
`else
  assign bus.mapped_light = raw_q;
`endif

  assign bus.frame_pending = pend_q;
  assign bus.drop_cnt      = drop_q;
endmodule

// File: tb/tb_light_map_server.sv
// Directed self-checking bench for light_map_server.
// Expected read latency follows LIGHT_MAP_GAMMA_EN.
module tb_light_map_server;
`ifdef LIGHT_MAP_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic I_clk;
  logic sys_rst;
  int   checks;
  int   errors;

  light_map_server_if #(.IDX_W(9), .DATA_W(16)) bus ();

  light_map_server #(.ZONES(288), .IDX_W(9), .DATA_W(16)) dut (
    .I_clk  (I_clk),
    .sys_rst(sys_rst),
    .bus    (bus.slave)
  );

  initial I_clk = 1'b0;
  always #10 I_clk = ~I_clk;

  function automatic logic [15:0] gexp(input logic [15:0] v);
    logic [31:0] p;
`ifdef LIGHT_MAP_GAMMA_EN
    p = 32'(v) * 32'(v);
    return p[31:16];
`else
    p = 32'(v);
    return p[15:0];
`endif
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic write_frame(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.zone_valid = 1'b1;
      bus.zone_index = 9'(i);
      bus.zone_value = base + 16'(i);
      tick();
    end
    bus.zone_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input int idx,
                    input logic [15:0] expv);
    bus.light_index = 9'(idx);
    tick(LAT);
    chk(tag, 32'(bus.mapped_light), 32'(expv));
  endtask

  task automatic pulse_done;
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
  endtask

  task automatic pulse_refresh;
    bus.light_refresh = 1'b1;
    tick();
    bus.light_refresh = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sys_rst = 1'b1;
    bus.zone_valid = 1'b0;
    bus.zone_index = '0;
    bus.zone_value = '0;
    bus.frame_done = 1'b0;
    bus.light_refresh = 1'b0;
    bus.light_index = '0;
    tick(2);
    sys_rst = 1'b0;
    tick();

    chk("rst_mapped", 32'(bus.mapped_light), 0);
    chk("rst_pending", 32'(bus.frame_pending), 0);
    chk("rst_drop", 32'(bus.drop_cnt), 0);

    rd("pre_swap_read", 5, 16'h0000);
    pulse_refresh();
    chk("refresh_no_frame", 32'(bus.frame_pending), 0);
    rd("refresh_no_frame_rd", 5, 16'h0000);

    write_frame(16'h0100, 288);
    pulse_done();
    chk("done_pending", 32'(bus.frame_pending), 1);
    pulse_refresh();
    chk("swap_pending", 32'(bus.frame_pending), 0);
    for (int i = 0; i < 288; i++)
      rd($sformatf("sweep_%0d", i), i, gexp(16'h0100 + 16'(i)));

    bus.zone_valid = 1'b1;
    bus.zone_index = 9'd300;
    bus.zone_value = 16'hFFFF;
    tick();
    bus.zone_valid = 1'b0;
    rd("oob_read", 300, 16'h0000);
    rd("oob_keep0", 0, gexp(16'h0100));

    write_frame(16'h2000, 288);
    pulse_done();
    chk("b_pending", 32'(bus.frame_pending), 1);
    bus.zone_index = 9'd7;
    bus.zone_value = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      bus.zone_valid = 1'b1;
      tick();
    end
    bus.zone_valid = 1'b0;
    chk("drop_cnt3", 32'(bus.drop_cnt), 3);
    rd("held_a", 7, gexp(16'h0107));
    pulse_refresh();
    chk("b_swapped", 32'(bus.frame_pending), 0);
    rd("read_b7", 7, gexp(16'h2007));
    rd("read_b287", 287, gexp(16'h211F));

    write_frame(16'h3000, 288);
    bus.frame_done = 1'b1;
    bus.light_refresh = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    bus.light_refresh = 1'b0;
    chk("same_cyc_pending", 32'(bus.frame_pending), 0);
    rd("same_cyc_c10", 10, gexp(16'h300A));
    rd("same_cyc_c287", 287, gexp(16'h311F));
    chk("drop_kept", 32'(bus.drop_cnt), 3);

    write_frame(16'h4000, 100);
    sys_rst = 1'b1;
    tick(2);
    chk("midrst_mapped", 32'(bus.mapped_light), 0);
    chk("midrst_pending", 32'(bus.frame_pending), 0);
    chk("midrst_drop", 32'(bus.drop_cnt), 0);
    sys_rst = 1'b0;
    tick();
    rd("postrst_dataok0", 10, 16'h0000);
    write_frame(16'h5000, 288);
    pulse_done();
    chk("postrst_pending", 32'(bus.frame_pending), 1);
    pulse_refresh();
    rd("postrst_0", 0, gexp(16'h5000));
    rd("postrst_100", 100, gexp(16'h5064));
    rd("postrst_287", 287, gexp(16'h511F));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
